// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control sequencer: button conditioning plus the run/pause/lap
// state machine that gates, clears and freezes the BCD counter display path.

module StopwatchDebounce #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic            r_level_d;
  logic            r_press;
  logic [DB_W-1:0] r_cnt;

  // The press pulse is registered, so it lands one clock after the debounced
  // level rises and only rising edges of the filtered level produce it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

module stopwatch_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        lap_btn,
  input  logic [15:0] live_bcd,
  output logic        count_en,
  output logic        count_clr,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        at_max
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSE,
    LAP_RUN,
    LAP_PAUSE,
    MAXED
  } state_t;

  state_t      r_state;
  logic [15:0] r_lap_reg;
  logic        r_count_clr;
  logic        w_start_p;
  logic        w_lap_p;
  logic        w_at_max;

  StopwatchDebounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_start_db (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (start_btn),
    .o_press (w_start_p)
  );

  StopwatchDebounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_lap_db (
    .clk     (clk),
    .reset   (reset),
    .i_btn   (lap_btn),
    .o_press (w_lap_p)
  );

  assign w_at_max = (live_bcd == 16'h9999);

  // Within each state start is tested before lap, so a simultaneous lap press
  // is dropped; the max check outranks both while counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_lap_reg   <= 16'h0000;
      r_count_clr <= 1'b0;
    end else begin
      r_count_clr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_p) r_state <= RUN;
        end
        RUN: begin
          if (w_at_max) begin
            r_state <= MAXED;
          end else if (w_start_p) begin
            r_state <= PAUSE;
          end else if (w_lap_p) begin
            r_state   <= LAP_RUN;
            r_lap_reg <= live_bcd;
          end
        end
        LAP_RUN: begin
          if (w_at_max)       r_state <= MAXED;
          else if (w_start_p) r_state <= LAP_PAUSE;
          else if (w_lap_p)   r_state <= RUN;
        end
        PAUSE: begin
          if (w_start_p) begin
            r_state <= RUN;
          end else if (w_lap_p) begin
            r_state     <= IDLE;
            r_count_clr <= 1'b1;
          end
        end
        LAP_PAUSE: begin
          if (w_start_p)    r_state <= LAP_RUN;
          else if (w_lap_p) r_state <= PAUSE;
        end
        MAXED: begin
          if (w_lap_p) begin
            r_state     <= IDLE;
            r_count_clr <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gating on at_max directly keeps the counter from wrapping on the cycle
  // before the MAXED transition takes effect.
  assign running    = (r_state == RUN) || (r_state == LAP_RUN);
  assign lap_active = (r_state == LAP_RUN) || (r_state == LAP_PAUSE);
  assign count_en   = running && !w_at_max;
  assign count_clr  = r_count_clr;
  assign disp_bcd   = lap_active ? r_lap_reg : live_bcd;
  assign at_max     = w_at_max;

endmodule
